// File: rtl/mem_req_queue_pkg.sv
// rtl/mem_req_queue_pkg.sv - size encodings, bus widths and request-format helpers
package mem_req_queue_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int ADDR_W        = 32;
    localparam int DATA_W        = 32;
    localparam int STRB_W        = DATA_W / 8;
    localparam int ENTRY_FLAGS_W = 2;

    // Any size with bit 1 set is handled as a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (size == SIZE_HALF) begin
            mis = addr_lo[0];
        end else if (size[1]) begin
            mis = |addr_lo;
        end
        return mis;
    endfunction

    function automatic logic [STRB_W-1:0] make_wstrb(input logic wr, input logic [1:0] size,
                                                      input logic [1:0] addr_lo);
        logic [STRB_W-1:0] strb;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << addr_lo;
            SIZE_HALF: strb = 4'b0011 << addr_lo;
            default:   strb = 4'b1111;
        endcase
        return wr ? strb : '0;
    endfunction

    function automatic logic [DATA_W-1:0] make_wdata(input logic [1:0] size, input logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] rep;
        case (size)
            SIZE_BYTE: rep = {4{data[7:0]}};
            SIZE_HALF: rep = {2{data[15:0]}};
            default:   rep = data;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/mem_req_queue_if.sv
// rtl/mem_req_queue_if.sv - request, SRAM-like and response channels of the memory request queue
interface mem_req_queue_if #(
    parameter int TAG_W = 8
);
    import mem_req_queue_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_wr;
    logic [1:0]        in_size;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;
    logic [TAG_W-1:0]  in_tag;

    logic              data_sram_req;
    logic              data_sram_wr;
    logic [1:0]        data_sram_size;
    logic [ADDR_W-1:0] data_sram_addr;
    logic [STRB_W-1:0] data_sram_wstrb;
    logic [DATA_W-1:0] data_sram_wdata;
    logic              data_sram_addr_ok;
    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;

    logic              rsp_valid;
    logic              rsp_wr;
    logic              rsp_ale;
    logic [TAG_W-1:0]  rsp_tag;
    logic [DATA_W-1:0] rsp_rdata;

    modport slave (
        input  in_valid, in_wr, in_size, in_addr, in_wdata, in_tag,
        output in_ready,
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
               data_sram_wstrb, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        output rsp_valid, rsp_wr, rsp_ale, rsp_tag, rsp_rdata
    );

    modport master (
        output in_valid, in_wr, in_size, in_addr, in_wdata, in_tag,
        input  in_ready,
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
               data_sram_wstrb, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        input  rsp_valid, rsp_wr, rsp_ale, rsp_tag, rsp_rdata
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - pointer-based FIFO storage; occupancy is tracked by the owner
module sync_fifo #(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o
);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = bump(wr_ptr_q);
        if (pop_i)  rd_ptr_d = bump(rd_ptr_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o  = mem_q[rd_ptr_q];
    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;

endmodule

// File: rtl/mem_req_queue.sv
// rtl/mem_req_queue.sv - single-issue memory request queue with in-order completion and flush discard
module mem_req_queue
    import mem_req_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    output logic            busy,
    mem_req_queue_if.slave  bus
);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = TAG_W + ENTRY_FLAGS_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic              iss_valid_q, iss_valid_d;
    logic              iss_discard_q, iss_discard_d;
    logic              iss_wr_q, iss_wr_d;
    logic [1:0]        iss_size_q, iss_size_d;
    logic [ADDR_W-1:0] iss_addr_q, iss_addr_d;
    logic [STRB_W-1:0] iss_wstrb_q, iss_wstrb_d;
    logic [DATA_W-1:0] iss_wdata_q, iss_wdata_d;
    logic [TAG_W-1:0]  iss_tag_q, iss_tag_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  discard_q, discard_d;

    logic               accept, misaligned, issue_done, push, pop, push_discard;
    logic               head_valid, head_wr, head_ale, head_done;
    logic [ENTRY_W-1:0] push_entry, head_entry;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;

    assign misaligned   = is_misaligned(bus.in_size, bus.in_addr[1:0]);
    assign bus.in_ready = !iss_valid_q && (count_q < FULL) && !flush && !reset;
    assign accept       = bus.in_valid && bus.in_ready;
    assign issue_done   = iss_valid_q && bus.data_sram_addr_ok;
    assign push         = issue_done || (accept && misaligned);
    assign push_discard = issue_done && (iss_discard_q || flush);
    assign push_entry   = issue_done ? {iss_tag_q, iss_wr_q, 1'b0} : {bus.in_tag, bus.in_wr, 1'b1};

    // Head is judged on registered occupancy, so a same-cycle push never completes early.
    assign head_valid        = (count_q != '0);
    assign {head_wr, head_ale} = head_entry[1:0];
    assign head_done         = head_valid && (head_ale || bus.data_sram_data_ok);
    assign pop               = head_done;

    assign bus.data_sram_req   = iss_valid_q;
    assign bus.data_sram_wr    = iss_wr_q;
    assign bus.data_sram_size  = iss_size_q;
    assign bus.data_sram_addr  = iss_addr_q;
    assign bus.data_sram_wstrb = iss_wstrb_q;
    assign bus.data_sram_wdata = iss_wdata_q;

    assign bus.rsp_valid = head_done && !discard_q[rd_ptr] && !flush && !reset;
    assign bus.rsp_wr    = head_wr;
    assign bus.rsp_ale   = head_ale;
    assign bus.rsp_tag   = head_entry[ENTRY_W-1:ENTRY_FLAGS_W];
    assign bus.rsp_rdata = (head_ale || head_wr) ? '0 : bus.data_sram_rdata;
    assign busy          = iss_valid_q || head_valid;

    always_comb begin
        iss_valid_d   = iss_valid_q;
        iss_discard_d = iss_discard_q;
        iss_wr_d      = iss_wr_q;
        iss_size_d    = iss_size_q;
        iss_addr_d    = iss_addr_q;
        iss_wstrb_d   = iss_wstrb_q;
        iss_wdata_d   = iss_wdata_q;
        iss_tag_d     = iss_tag_q;
        if (accept && !misaligned) begin
            iss_valid_d   = 1'b1;
            iss_discard_d = 1'b0;
            iss_wr_d      = bus.in_wr;
            iss_size_d    = bus.in_size;
            iss_addr_d    = bus.in_addr;
            iss_wstrb_d   = make_wstrb(bus.in_wr, bus.in_size, bus.in_addr[1:0]);
            iss_wdata_d   = make_wdata(bus.in_size, bus.in_wdata);
            iss_tag_d     = bus.in_tag;
        end else if (issue_done) begin
            iss_valid_d = 1'b0;
        end
        // The pending SRAM request keeps its payload; flush only marks it for silent drain.
        if (flush && iss_valid_q) iss_discard_d = 1'b1;

        discard_d = flush ? '1 : discard_q;
        if (push) discard_d[wr_ptr] = push_discard;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_valid_q   <= 1'b0;
            iss_discard_q <= 1'b0;
            iss_wr_q      <= 1'b0;
            iss_size_q    <= '0;
            iss_addr_q    <= '0;
            iss_wstrb_q   <= '0;
            iss_wdata_q   <= '0;
            iss_tag_q     <= '0;
            count_q       <= '0;
            discard_q     <= '0;
        end else begin
            iss_valid_q   <= iss_valid_d;
            iss_discard_q <= iss_discard_d;
            iss_wr_q      <= iss_wr_d;
            iss_size_q    <= iss_size_d;
            iss_addr_q    <= iss_addr_d;
            iss_wstrb_q   <= iss_wstrb_d;
            iss_wdata_q   <= iss_wdata_d;
            iss_tag_q     <= iss_tag_d;
            count_q       <= count_d;
            discard_q     <= discard_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_i   (push),
        .pop_i    (pop),
        .wdata_i  (push_entry),
        .rdata_o  (head_entry),
        .wr_ptr_o (wr_ptr),
        .rd_ptr_o (rd_ptr)
    );

endmodule
